// File: rtl/sdr_mon_pkg.sv
// Shared types for the SDRAM bank monitor: bank states, decoded bus commands,
// violation codes and the command decoder.
package sdr_mon_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    ACTIVE  = 2'd2,
    CLOSING = 2'd3
  } bank_st_e;

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_OPENING = OPENING;
  localparam logic [1:0] S_ACTIVE  = ACTIVE;
  localparam logic [1:0] S_CLOSING = CLOSING;

  typedef enum logic [3:0] {
    CMD_DESEL, CMD_NOP, CMD_ACT, CMD_RD, CMD_WR,
    CMD_BST, CMD_PRE, CMD_REF, CMD_LMR
  } sdr_cmd_e;

  typedef enum logic [2:0] {
    V_NONE     = 3'd0,
    V_ACT_OPEN = 3'd1,
    V_TRCD     = 3'd2,
    V_CLOSED   = 3'd3,
    V_TRAS     = 3'd4,
    V_TRP      = 3'd5,
    V_REF_OPEN = 3'd6,
    V_TRFC     = 3'd7
  } viol_e;

  function automatic sdr_cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                          input logic cas_n, input logic we_n);
    sdr_cmd_e c;
    c = CMD_NOP;
    if (cs_n) c = CMD_DESEL;
    else begin
      case ({ras_n, cas_n, we_n})
        3'b111:  c = CMD_NOP;
        3'b011:  c = CMD_ACT;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        3'b110:  c = CMD_BST;
        3'b010:  c = CMD_PRE;
        3'b001:  c = CMD_REF;
        default: c = CMD_LMR;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sdr_bank_monitor_if.sv
// Ram-side SDRAM command bus as seen by the monitor.
interface sdr_bank_monitor_if #(
  parameter int BA_W = 2,
  parameter int AW   = 13
);
  // No valid/ready: every sdram_clk edge with sdr_cke=1 samples exactly one
  // command ({cs_n,ras_n,cas_n,we_n}, sdr_ba, sdr_addr); the monitor never back-pressures.
  logic            sdr_cke;
  logic            sdr_cs_n;
  logic            sdr_ras_n;
  logic            sdr_cas_n;
  logic            sdr_we_n;
  logic [BA_W-1:0] sdr_ba;
  logic [AW-1:0]   sdr_addr;

  modport master (output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr);
  modport slave  (input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr);
endinterface

// File: rtl/sdr_mon_bank.sv
// One bank's tracker: state FSM, tRCD/tRAS/tRP timers, open row, and the
// per-bank violation bits (bit k = violation code k+1).
module sdr_mon_bank
  import sdr_mon_pkg::*;
#(
  parameter int AW    = 13,
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int T_RAS = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_en,
  input  sdr_cmd_e      cmd,
  input  logic          sel,
  input  logic          a10,
  input  logic [AW-1:0] addr,
  output logic [1:0]    st,
  output logic [AW-1:0] row,
  output logic [5:0]    viol
);

  localparam logic [TMR_W-1:0] RCD_LD = TMR_W'(T_RCD - 1);
  localparam logic [TMR_W-1:0] RAS_LD = TMR_W'(T_RAS - 1);
  localparam logic [TMR_W-1:0] RP_LD  = TMR_W'(T_RP - 1);

  logic [1:0]       st_q, st_d, eff;
  logic [TMR_W-1:0] rcd_q, rcd_d, ras_q, ras_d, rp_q, rp_d;
  logic [AW-1:0]    row_q, row_d;

  always_comb begin
    // An expired OPENING/CLOSING timer already counts as the next state this edge.
    eff = st_q;
    if (st_q == S_OPENING && rcd_q == '0) eff = S_ACTIVE;
    if (st_q == S_CLOSING && rp_q == '0)  eff = S_IDLE;
    st_d  = eff;
    rcd_d = (rcd_q != '0) ? rcd_q - TMR_W'(1) : '0;
    ras_d = (ras_q != '0) ? ras_q - TMR_W'(1) : '0;
    rp_d  = (rp_q  != '0) ? rp_q  - TMR_W'(1) : '0;
    row_d = row_q;
    viol  = '0;
    if (cmd_en) begin
      case (cmd)
        CMD_ACT: if (sel) begin
          if (eff == S_OPENING || eff == S_ACTIVE) viol[0] = 1'b1;
          if (eff == S_CLOSING) viol[4] = 1'b1;
          st_d  = S_OPENING;
          rcd_d = RCD_LD;
          ras_d = RAS_LD;
          row_d = addr;
        end
        CMD_RD, CMD_WR: if (sel) begin
          if (eff == S_IDLE || eff == S_CLOSING) viol[2] = 1'b1;
          else begin
            if (eff == S_OPENING) viol[1] = 1'b1;
            if (a10) begin
              st_d = S_CLOSING;
              rp_d = RP_LD;
            end
          end
        end
        CMD_BST: if (sel && (eff == S_IDLE || eff == S_CLOSING)) viol[2] = 1'b1;
        CMD_PRE: if ((sel || a10) && (eff == S_OPENING || eff == S_ACTIVE)) begin
          if (ras_q != '0) viol[3] = 1'b1;
          st_d = S_CLOSING;
          rp_d = RP_LD;
        end
        CMD_REF, CMD_LMR: if (eff != S_IDLE) viol[5] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      rcd_q <= '0;
      ras_q <= '0;
      rp_q  <= '0;
      row_q <= '0;
    end else begin
      st_q  <= st_d;
      rcd_q <= rcd_d;
      ras_q <= ras_d;
      rp_q  <= rp_d;
      row_q <= row_d;
    end
  end

  assign st  = st_q;
  assign row = row_q;

endmodule

// File: rtl/sdr_bank_monitor.sv
// Passive SDRAM command-bus monitor: per-bank trackers, global tRFC timer and
// violation report register. Define SDR_MON_ERRCNT_EN to add the err_cnt output.
module sdr_bank_monitor
  import sdr_mon_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int AW        = 13,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int T_RAS     = 6,
  parameter int T_RFC     = 8,
  localparam int BA_W     = $clog2(NUM_BANKS)
) (
  input  logic                    sdram_clk,
  input  logic                    sdram_resetn,
  sdr_bank_monitor_if.slave       bus,
  input  logic                    viol_clr,
  output logic [NUM_BANKS*2-1:0]  bank_st,
  output logic [NUM_BANKS*AW-1:0] open_row,
  output logic                    viol_valid,
  output logic [2:0]              viol_code,
  output logic [BA_W-1:0]         viol_bank,
  output logic [NUM_BANKS-1:0]    viol_sticky
`ifdef SDR_MON_ERRCNT_EN
  ,
  output logic [15:0]             err_cnt
`endif
);

  sdr_cmd_e         cmd;
  logic             cmd_en;
  logic [5:0]       bviol [NUM_BANKS];
  logic [TMR_W-1:0] rfc_q;
  logic             trfc;
  viol_e            code_d;
  logic [BA_W-1:0]  bank_d;
  logic [NUM_BANKS-1:0] hit_mask;
  logic             any_viol;

  assign cmd    = decode_cmd(bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n);
  assign cmd_en = bus.sdr_cke;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    sdr_mon_bank #(.AW(AW), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)) u_bank (
      .clk    (sdram_clk),
      .rst_n  (sdram_resetn),
      .cmd_en (cmd_en),
      .cmd    (cmd),
      .sel    (bus.sdr_ba == BA_W'(gi)),
      .a10    (bus.sdr_addr[10]),
      .addr   (bus.sdr_addr),
      .st     (bank_st[2*gi +: 2]),
      .row    (open_row[AW*gi +: AW]),
      .viol   (bviol[gi])
    );
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn)                 rfc_q <= '0;
    else if (cmd_en && cmd == CMD_REF) rfc_q <= TMR_W'(T_RFC - 1);
    else if (rfc_q != '0)              rfc_q <= rfc_q - TMR_W'(1);
  end

  assign trfc = cmd_en && (rfc_q != '0) && (cmd != CMD_NOP) && (cmd != CMD_DESEL);

  // TRFC outranks everything and is attributed to the addressed bank; otherwise
  // the highest per-bank code wins and the lowest bank carrying it is reported.
  always_comb begin
    code_d   = V_NONE;
    bank_d   = '0;
    hit_mask = '0;
    for (int b = 0; b < NUM_BANKS; b++) hit_mask[b] = |bviol[b];
    if (trfc) begin
      code_d   = V_TRFC;
      bank_d   = bus.sdr_ba;
      hit_mask = hit_mask | (NUM_BANKS'(1) << bus.sdr_ba);
    end else begin
      for (int c = 5; c >= 0; c--) begin
        if (code_d == V_NONE) begin
          for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (bviol[b][c]) begin
              code_d = viol_e'(3'(c + 1));
              bank_d = BA_W'(b);
            end
          end
        end
      end
    end
  end

  assign any_viol = (code_d != V_NONE);

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      viol_valid  <= 1'b0;
      viol_code   <= V_NONE;
      viol_bank   <= '0;
      viol_sticky <= '0;
    end else begin
      viol_valid  <= any_viol;
      if (any_viol) begin
        viol_code <= code_d;
        viol_bank <= bank_d;
      end
      viol_sticky <= (viol_clr ? '0 : viol_sticky) | hit_mask;
    end
  end

`ifdef SDR_MON_ERRCNT_EN
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn)                         err_cnt <= '0;
    else if (viol_clr)                         err_cnt <= any_viol ? 16'd1 : 16'd0;
    else if (any_viol && err_cnt != 16'hFFFF)  err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule
